// File: rtl/cardinal_nic_pkg.sv
// Shared constants for the cardinal NIC: processor address map, VC bit position
// and the NOP encoding used by the core.
package cardinal_nic_pkg;

  localparam logic [1:0] NIC_IN_BUF   = 2'b00;
  localparam logic [1:0] NIC_IN_STAT  = 2'b01;
  localparam logic [1:0] NIC_OUT_BUF  = 2'b10;
  localparam logic [1:0] NIC_OUT_STAT = 2'b11;

  // Packet bit 0 (MSB in the core's [0:N-1] numbering) carries the virtual channel.
  localparam int unsigned VC_BIT = 0;

  localparam logic [0:5] NOP = 6'b111100;

endpackage

// File: rtl/nic_chan_buf.sv
// One-entry channel buffer with a full flag. A load is ignored while full;
// a clear only drops the flag, the stale data word stays until overwritten.
module nic_chan_buf #(
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [0:DATA_W-1] data_i,
  input  logic              clr_i,
  output logic [0:DATA_W-1] data_o,
  output logic              full_o
);

  logic [0:DATA_W-1] buf_q, buf_d;
  logic              full_q, full_d;

  always_comb begin
    buf_d  = buf_q;
    full_d = full_q;
    if (full_q) begin
      if (clr_i) full_d = 1'b0;
    end else if (load_i) begin
      buf_d  = data_i;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q  <= '0;
      full_q <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      full_q <= full_d;
    end
  end

  assign data_o = buf_q;
  assign full_o = full_q;

endmodule

// File: rtl/cardinal_nic.sv
// Network interface between cardinal_processor and its router port: address
// decode, registered read data and send/ready handshake with VC polarity gating.
module cardinal_nic
  import cardinal_nic_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [0:1]        addr,
  input  logic [0:DATA_W-1] d_in,
  output logic [0:DATA_W-1] d_out,
  input  logic              nicEn,
  input  logic              nicWrEn,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [0:DATA_W-1] net_di,
  output logic              net_so,
  input  logic              net_ro,
  output logic [0:DATA_W-1] net_do,
  input  logic              net_polarity
);

  logic              rd_en, wr_en;
  logic              in_load, in_clr, out_load;
  logic              in_full, out_full;
  logic [0:DATA_W-1] in_buf, out_buf;
  logic [0:DATA_W-1] rd_data;
  logic [0:DATA_W-1] d_out_q;

  assign rd_en = nicEn & ~nicWrEn;
  assign wr_en = nicEn & nicWrEn;

  assign net_ri = ~in_full & ~reset;
  assign net_so = out_full & net_ro & (out_buf[VC_BIT] == net_polarity) & ~reset;
  assign net_do = out_buf;

  assign in_load  = net_si & net_ri;
  assign in_clr   = rd_en & (addr == NIC_IN_BUF);
  assign out_load = wr_en & (addr == NIC_OUT_BUF);

  nic_chan_buf #(.DATA_W(DATA_W)) u_in_chan (
    .clk    (clk),
    .reset  (reset),
    .load_i (in_load),
    .data_i (net_di),
    .clr_i  (in_clr),
    .data_o (in_buf),
    .full_o (in_full)
  );

  nic_chan_buf #(.DATA_W(DATA_W)) u_out_chan (
    .clk    (clk),
    .reset  (reset),
    .load_i (out_load),
    .data_i (d_in),
    .clr_i  (net_so),
    .data_o (out_buf),
    .full_o (out_full)
  );

  // Status words place the flag in the last bit (bit DATA_W-1).
  always_comb begin
    rd_data = '0;
    unique case (addr)
      NIC_IN_BUF:   rd_data = in_buf;
      NIC_IN_STAT:  rd_data = {{(DATA_W-1){1'b0}}, in_full};
      NIC_OUT_BUF:  rd_data = '0;
      NIC_OUT_STAT: rd_data = {{(DATA_W-1){1'b0}}, out_full};
      default:      rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)      d_out_q <= '0;
    else if (rd_en) d_out_q <= rd_data;
  end

  assign d_out = d_out_q;

endmodule

// File: tb/tb_cardinal_nic.sv
// Directed plus randomized bench for cardinal_nic against a transaction-level
// model of the two one-word channels.
module tb_cardinal_nic;

  logic        clk = 1'b0;
  logic        reset;
  logic [0:1]  addr;
  logic [0:63] d_in, d_out, net_di, net_do;
  logic        nicEn, nicWrEn, net_si, net_ri, net_so, net_ro, net_polarity;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Model state in the spec's [0:63] numbering.
  logic        m_in_full, m_out_full;
  logic [0:63] m_in_buf, m_out_buf, m_d_out;

  always #5 clk = ~clk;

  cardinal_nic dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .net_si(net_si), .net_ri(net_ri),
    .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
    .net_polarity(net_polarity)
  );

  task automatic chk(input string tag, input logic [0:63] obs, input logic [0:63] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic en, input logic we, input logic [0:1] a, input logic [0:63] din);
    nicEn = en; nicWrEn = we; addr = a; d_in = din;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, '0);
    net_si = 1'b0;
  endtask

  // One clock: check combinational outputs against the model before the edge,
  // advance the model from pre-edge state, then check d_out after the edge.
  task automatic tick();
    logic        e_ri, e_so, rd, wr;
    logic [0:63] stat;
    #1;
    e_ri = !m_in_full && !reset;
    e_so = m_out_full && net_ro && (m_out_buf[0] == net_polarity) && !reset;
    chk("net_ri", {63'b0, net_ri}, {63'b0, e_ri});
    chk("net_so", {63'b0, net_so}, {63'b0, e_so});
    chk("net_do", net_do, m_out_buf);
    rd = nicEn && !nicWrEn;
    wr = nicEn && nicWrEn;
    @(posedge clk);
    if (reset) begin
      m_in_full = 0; m_out_full = 0; m_in_buf = '0; m_out_buf = '0; m_d_out = '0;
    end else begin
      if (rd) begin
        stat = '0;
        case (addr)
          2'b00: m_d_out = m_in_buf;
          2'b01: begin stat[63] = m_in_full;  m_d_out = stat; end
          2'b10: m_d_out = '0;
          default: begin stat[63] = m_out_full; m_d_out = stat; end
        endcase
      end
      if (rd && addr == 2'b00) m_in_full = 0;
      if (net_si && e_ri) begin m_in_buf = net_di; m_in_full = 1; end
      if (e_so) m_out_full = 0;
      else if (wr && addr == 2'b10 && !m_out_full) begin
        m_out_buf = d_in; m_out_full = 1;
      end
    end
    #1;
    chk("d_out", d_out, m_d_out);
  endtask

  initial begin
    logic [0:63] pkt_a, pkt_b, tmp;
    m_in_full = 0; m_out_full = 0; m_in_buf = '0; m_out_buf = '0; m_d_out = '0;
    reset = 1'b1; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;
    idle();
    @(negedge clk);
    tick(); tick();
    reset = 1'b0;
    idle(); tick();

    // Reset state: status read of 01 is 0, ready high, no send.
    drive(1, 0, 2'b01, '0); tick();
    chk("rst_stat_in", d_out, 64'h0);
    idle(); tick();
    chk("rst_net_ri", {63'b0, net_ri}, 64'h1);
    chk("rst_net_so", {63'b0, net_so}, 64'h0);

    // Router capture then processor drain.
    net_si = 1; net_di = 64'hDEAD_BEEF_0000_0001; tick();
    net_si = 0; net_di = '0; #1;
    chk("ri_fall", {63'b0, net_ri}, 64'h0);
    drive(1, 0, 2'b01, '0); tick();
    chk("in_stat_full", d_out, 64'h1);
    drive(1, 0, 2'b00, '0); tick();
    chk("in_buf_read", d_out, 64'hDEAD_BEEF_0000_0001);
    drive(1, 0, 2'b01, '0); tick();
    chk("in_stat_empty", d_out, 64'h0);
    idle(); tick();

    // Output send gated by VC polarity.
    net_ro = 1; net_polarity = 0;
    drive(1, 1, 2'b10, 64'h8000_0000_0000_00AA); tick();
    idle(); tick(); tick();
    net_polarity = 1; #1;
    chk("so_on_polarity", {63'b0, net_so}, 64'h1);
    chk("net_do_val", net_do, 64'h8000_0000_0000_00AA);
    tick(); tick();
    drive(1, 0, 2'b11, '0); tick();
    chk("out_stat_empty", d_out, 64'h0);
    drive(1, 0, 2'b10, '0); tick();
    chk("read_out_buf_zero", d_out, 64'h0);

    // Back-to-back writes with router stalled: second one dropped.
    net_ro = 0;
    pkt_a = 64'h1234_5678_9ABC_DEF0; pkt_b = 64'h0FED_CBA9_8765_4321;
    drive(1, 1, 2'b10, pkt_a); tick();
    drive(1, 1, 2'b10, pkt_b); tick();
    idle(); tick();
    chk("drop_second", net_do, pkt_a);
    drive(1, 1, 2'b00, pkt_b); tick();
    drive(1, 1, 2'b11, pkt_b); tick();
    net_ro = 1; net_polarity = 0; idle(); tick(); tick();

    // Input read and new packet in the same cycle.
    net_si = 1; net_di = 64'hAAAA_0000_0000_0001; tick();
    drive(1, 0, 2'b00, '0); net_di = 64'hBBBB_0000_0000_0002; tick();
    chk("same_cyc_read", d_out, 64'hAAAA_0000_0000_0001);
    drive(0, 0, 2'b00, '0); tick();
    net_si = 0; drive(1, 0, 2'b00, '0); tick();
    chk("held_pkt", d_out, 64'hBBBB_0000_0000_0002);
    drive(1, 0, 2'b01, '0); tick();
    chk("no_dup", d_out, 64'h0);

    // Reset with both buffers full.
    net_ro = 0;
    net_si = 1; net_di = 64'h0123_4567_89AB_CDEF;
    drive(1, 1, 2'b10, 64'hFFFF_0000_0000_0001); tick();
    net_si = 0; drive(1, 0, 2'b00, '0); tick();
    idle(); reset = 1; net_ro = 1; net_polarity = 1; #1;
    chk("so_in_reset", {63'b0, net_so}, 64'h0);
    tick();
    chk("rst_d_out", d_out, 64'h0);
    reset = 0; net_ro = 0;
    drive(1, 0, 2'b01, '0); tick();
    chk("rst_in_flag", d_out, 64'h0);
    drive(1, 0, 2'b11, '0); tick();
    chk("rst_out_flag", d_out, 64'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      reset        = ($urandom_range(0, 49) == 0);
      nicEn        = $urandom_range(0, 1);
      nicWrEn      = $urandom_range(0, 1);
      addr         = 2'($urandom_range(0, 3));
      tmp          = {$urandom, $urandom};
      d_in         = tmp;
      tmp          = {$urandom, $urandom};
      net_di       = tmp;
      net_si       = $urandom_range(0, 1);
      net_ro       = $urandom_range(0, 1);
      net_polarity = $urandom_range(0, 1);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/cardinal_nic.md
# cardinal_nic

Network interface controller between `cardinal_processor` and its local router port. It holds one input channel buffer (router → processor) and one output channel buffer (processor → router), each one 64-bit word deep with a full flag. The processor accesses these through a 2-bit memory-mapped address space. The processor side follows the core's decode/execute timing: control signals arrive in the decode cycle, and read data is consumed in the execute cycle. The router side uses a send/ready handshake with virtual-channel polarity gating.

## Interface
- `DATA_W`, default 64: packet and processor data width.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `addr`  in  [0:1]  register select, driven by the core's `addr_nic`.
- `d_in`  in  [0:DATA_W-1]  processor write data (`d_in_nic`).
- `d_out`  out  [0:DATA_W-1]  registered processor read data (`d_out_nic`).
- `nicEn`  in  1  access enable.
- `nicWrEn`  in  1  1 = write, 0 = read; only meaningful when `nicEn` = 1.
- `net_si`  in  1  router presents a packet to the NIC.
- `net_ri`  out  1  NIC can accept a packet.
- `net_di`  in  [0:DATA_W-1]  incoming packet.
- `net_so`  out  1  NIC sends a packet this cycle.
- `net_ro`  in  1  router can accept a packet.
- `net_do`  out  [0:DATA_W-1]  outgoing packet.
- `net_polarity`  in  1  router's current external VC phase.

## Operation
Address map:
- 00: input buffer. A read returns `in_buf` and clears `in_full`.
- 01: input status. A read returns `{63'b0, in_full}`; `in_full` is in bit 63.
- 10: output buffer. A write loads `out_buf` and sets `out_full`, but only if `out_full` = 0; otherwise the write is dropped.
- 11: output status. A read returns `{63'b0, out_full}`.

Accesses with no effect:
- Reading address 10 returns 0.
- Writes to addresses 00, 01 and 11 are ignored.

Input channel:
- `net_ri` = ~`in_full` & ~`reset`.
- On an edge where `net_si` & `net_ri`: `in_buf` ← `net_di` and `in_full` ← 1.
- If `net_si` is asserted while `net_ri` = 0, the data is not captured; the router must hold it.

Output channel:
- `net_do` = `out_buf`.
- `net_so` = `out_full` & `net_ro` & (`out_buf[0]` == `net_polarity`) & ~`reset`. Bit 0 is the packet's VC bit.
- On an edge where `net_so` = 1, `out_full` ← 0.

Simultaneous events (all decisions use pre-edge state):
- Input buffer read in the same cycle as `net_si`: no capture occurs, because `net_ri` was 0. The buffer becomes empty and `net_ri` rises the next cycle.
- Output buffer write in the same cycle as a send: the write is dropped, because `out_full` was 1. The send completes, and software must re-poll status.

`d_out`:
- Updates only on a read (`nicEn` & ~`nicWrEn`).
- Holds its value otherwise.

Reset: when `reset` is asserted, all of the following clear to 0:
- `in_full`, `out_full`, `in_buf`, `out_buf` and `d_out`.
- The outputs `net_so` and `net_ri`.

Reset mid-transfer discards any buffered packets.

## Timing
- Processor read latency is 1 cycle: `addr`, `nicEn` and `nicWrEn` are sampled at edge N, and `d_out` is valid from edge N to edge N+1. This matches the core's execute-stage `wd` mux.
- A processor write takes effect at the sampling edge. The status read in the following cycle reflects it.
- Router capture is one edge: `in_full` is visible through a status read one cycle later, and `net_ri` falls after the capture edge.
- Send is one edge from `out_full` being set, provided `net_ro` and polarity match. The minimum processor-write-to-`net_so` delay is 1 cycle.
- There is no combinational path from `net_di` to `d_out`, nor from `d_in` to `net_do`.

## Structure
- Package `cardinal_nic_pkg` holds:
  - Address constants `NIC_IN_BUF`, `NIC_IN_STAT`, `NIC_OUT_BUF`, `NIC_OUT_STAT`.
  - The VC bit index.
  - The `NOP` encoding shared with the core.
- Sub-module `nic_chan_buf`: one-entry register plus full flag, with load/clear ports and a load-ignored-when-full rule. It is instantiated twice.
- The top level holds the address decode, the `d_out` register and the handshake gating.

## Test plan
- Reset, then a status read of address 01 → `d_out` = 0 the next cycle; `net_ri` = 1 and `net_so` = 0.
- Router drives `net_si` = 1 with `net_di` = 64'hDEAD_BEEF_0000_0001 → `net_ri` falls next cycle. A read of 01 returns 1; a read of 00 returns DEAD_BEEF_0000_0001; a following read of 01 returns 0 and `net_ri` = 1.
- Write 64'h8000_0000_0000_00AA to address 10 with `net_polarity` = 0 and `net_ro` = 1 → `net_so` stays 0. Toggle polarity to 1 → `net_so` = 1 for exactly one cycle with `net_do` = 8000…00AA, then a read of 11 returns 0.
- Two back-to-back writes to 10 while `net_ro` = 0 → the second is dropped, and `out_buf` holds the first value.
- Input read and a new `net_si` in the same cycle → the new packet is captured one cycle later, with no loss or duplication.
- Assert `reset` while both buffers are full → both flags and `d_out` are 0 after the edge, and `net_so` = 0 during reset.
